// File: rtl/mlp_pkg.sv
// Shared types and helpers for the sequential MLP engine: FSM states,
// accumulator sizing, saturation/ReLU classification and weight addressing.
package mlp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    SAT_PASS,
    SAT_HI,
    SAT_LO,
    SAT_ZERO
  } sat_e;

  function automatic int acc_size(input int data_size);
    return 2 * data_size + 4;
  endfunction

  // Classifies a (sign-extended) value against a dw-bit signed range.
  function automatic sat_e sat_relu(input logic signed [63:0] v, input int dw,
                                    input logic relu);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (relu && (v < 64'sd0)) return SAT_ZERO;
    if (v > hi) return SAT_HI;
    if (v < lo) return SAT_LO;
    return SAT_PASS;
  endfunction

  function automatic int wt_index(input int layer, input int row, input int col,
                                  input int max_cr);
    return layer * max_cr * max_cr + row * max_cr + col;
  endfunction

endpackage

// File: rtl/mlp_seq_engine_if.sv
// Handshake, configuration and weight-write bus of the sequential MLP engine.
interface mlp_seq_engine_if #(
  parameter int DATA_SIZE        = 8,
  parameter int NUM_LAYERS       = 2,
  parameter int MAX_COL_ROWS     = 9,
  parameter int MAX_COL_ROW_BITS = 6,
  parameter int WT_ADDR_WIDTH    = 8
);
  logic                                        new_data;
  logic                                        in_ready;
  logic [MAX_COL_ROWS-1:0][DATA_SIZE-1:0]      input_data;
  logic [NUM_LAYERS-1:0][MAX_COL_ROW_BITS-1:0] all_rows_sizes;
  logic [NUM_LAYERS-1:0][MAX_COL_ROW_BITS-1:0] all_cols_sizes;
  logic                                        wt_we;
  logic [WT_ADDR_WIDTH-1:0]                    wt_addr;
  logic [DATA_SIZE-1:0]                        wt_data;
  logic                                        output_ready;
  logic                                        out_taken;
  logic [MAX_COL_ROWS-1:0][DATA_SIZE-1:0]      mlp_output;
  logic                                        cfg_err;

  modport master (
    output new_data, input_data, all_rows_sizes, all_cols_sizes,
           wt_we, wt_addr, wt_data, out_taken,
    input  in_ready, output_ready, mlp_output, cfg_err
  );

  modport slave (
    input  new_data, input_data, all_rows_sizes, all_cols_sizes,
           wt_we, wt_addr, wt_data, out_taken,
    output in_ready, output_ready, mlp_output, cfg_err
  );
endinterface

// File: rtl/mlp_mac_lane.sv
// One signed multiply-accumulate lane; the product is sign-extended to ACC_SIZE.
module mlp_mac_lane #(
  parameter int DATA_SIZE = 8,
  parameter int ACC_SIZE  = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [DATA_SIZE-1:0] a,
  input  logic signed [DATA_SIZE-1:0] w,
  output logic signed [ACC_SIZE-1:0]  acc
);
  logic signed [2*DATA_SIZE-1:0] prod;
  logic signed [ACC_SIZE-1:0]    acc_q;

  assign prod = $signed({{DATA_SIZE{a[DATA_SIZE-1]}}, a}) *
                $signed({{DATA_SIZE{w[DATA_SIZE-1]}}, w});

  always_ff @(posedge clk) begin
    if (rst || clr) acc_q <= '0;
    else if (en) acc_q <= acc_q + {{(ACC_SIZE-2*DATA_SIZE){prod[2*DATA_SIZE-1]}}, prod};
  end

  assign acc = acc_q;
endmodule

// File: rtl/mlp_seq_engine.sv
// Time-multiplexed MLP core: NUM_LANES MAC lanes sweep rows of each layer.
// state | meaning: IDLE wait/accept, MAC one column per cycle, WRITE store lane
// results, NEXT swap activation buffers, DONE hold output until taken.
module mlp_seq_engine import mlp_pkg::*; #(
  parameter int DATA_SIZE        = 8,
  parameter int NUM_LAYERS       = 2,
  parameter int MAX_COL_ROWS     = 9,
  parameter int MAX_COL_ROW_BITS = 6,
  parameter int LAYER_BITS       = 2,
  parameter int NUM_LANES        = 1,
  parameter int ACC_SIZE         = acc_size(DATA_SIZE),
  parameter int FRAC_BITS        = 0,
  parameter int WT_ADDR_WIDTH    = 8
) (
  input logic             clk,
  input logic             rst,
  mlp_seq_engine_if.slave bus
);
  typedef logic [MAX_COL_ROWS-1:0][DATA_SIZE-1:0] vec_t;

  state_e                                      state_q;
  logic [LAYER_BITS-1:0]                       layer_q;
  logic [MAX_COL_ROW_BITS-1:0]                 col_q, rowbase_q;
  logic [NUM_LAYERS-1:0][MAX_COL_ROW_BITS-1:0] rows_q, cols_q;
  vec_t                                        act_q, nxt_q, nxt_d, out_q;
  logic                                        in_ready_q, out_valid_q, cfg_err_q;
  logic [DATA_SIZE-1:0]                        wmem [2**WT_ADDR_WIDTH];

  logic                        cfg_ok, last_layer, mac_en, lane_clr;
  logic [MAX_COL_ROW_BITS-1:0] cur_rows, cur_cols, next_rowbase;
  logic signed [ACC_SIZE-1:0]  acc      [NUM_LANES];
  logic                        lane_act [NUM_LANES];
  logic [MAX_COL_ROW_BITS-1:0] lane_row [NUM_LANES];
  logic [DATA_SIZE-1:0]        res      [NUM_LANES];

  assign cur_rows     = rows_q[layer_q];
  assign cur_cols     = cols_q[layer_q];
  assign next_rowbase = rowbase_q + MAX_COL_ROW_BITS'(NUM_LANES);
  assign last_layer   = (layer_q == LAYER_BITS'(NUM_LAYERS - 1));
  assign mac_en       = (state_q == S_MAC);
  assign lane_clr     = (state_q == S_WRITE);

  always_comb begin
    cfg_ok = 1'b1;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      if (bus.all_rows_sizes[l] == '0 || bus.all_cols_sizes[l] == '0 ||
          bus.all_rows_sizes[l] > MAX_COL_ROW_BITS'(MAX_COL_ROWS) ||
          bus.all_cols_sizes[l] > MAX_COL_ROW_BITS'(MAX_COL_ROWS)) cfg_ok = 1'b0;
    end
    for (int l = 1; l < NUM_LAYERS; l++) begin
      if (bus.all_cols_sizes[l] != bus.all_rows_sizes[l-1]) cfg_ok = 1'b0;
    end
  end

  // Weight store is deliberately outside reset so weights survive an abort.
  always_ff @(posedge clk) begin
    if (bus.wt_we && in_ready_q) wmem[bus.wt_addr] <= bus.wt_data;
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic signed [ACC_SIZE-1:0] sh;
    sat_e                       sel;

    assign lane_row[k] = rowbase_q + MAX_COL_ROW_BITS'(k);
    assign lane_act[k] = (lane_row[k] < cur_rows);

    mlp_mac_lane #(.DATA_SIZE(DATA_SIZE), .ACC_SIZE(ACC_SIZE)) u_lane (
      .clk (clk),
      .rst (rst),
      .clr (lane_clr),
      .en  (mac_en && lane_act[k]),
      .a   ($signed(act_q[col_q])),
      .w   ($signed(wmem[WT_ADDR_WIDTH'(wt_index(int'(layer_q), int'(lane_row[k]),
                                                 int'(col_q), MAX_COL_ROWS))])),
      .acc (acc[k])
    );

    assign sh  = acc[k] >>> FRAC_BITS;
    assign sel = sat_relu({{(64-ACC_SIZE){sh[ACC_SIZE-1]}}, sh}, DATA_SIZE, !last_layer);
    assign res[k] = (sel == SAT_PASS) ? sh[DATA_SIZE-1:0] :
                    (sel == SAT_HI)   ? {1'b0, {(DATA_SIZE-1){1'b1}}} :
                    (sel == SAT_LO)   ? {1'b1, {(DATA_SIZE-1){1'b0}}} : '0;
  end

  always_comb begin
    nxt_d = nxt_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (lane_act[k]) nxt_d[lane_row[k]] = res[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      out_q       <= '0;
      act_q       <= '0;
      nxt_q       <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      layer_q     <= '0;
      col_q       <= '0;
      rowbase_q   <= '0;
    end else begin
      cfg_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (bus.new_data) begin
          if (cfg_ok) begin
            rows_q <= bus.all_rows_sizes;
            cols_q <= bus.all_cols_sizes;
            for (int i = 0; i < MAX_COL_ROWS; i++)
              act_q[i] <= (i < int'(bus.all_cols_sizes[0])) ? bus.input_data[i] : '0;
            nxt_q      <= '0;
            layer_q    <= '0;
            col_q      <= '0;
            rowbase_q  <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_MAC;
          end else begin
            cfg_err_q <= 1'b1;
          end
        end
        S_MAC: begin
          if (col_q == cur_cols - 1'b1) begin
            col_q   <= '0;
            state_q <= S_WRITE;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        S_WRITE: begin
          nxt_q <= nxt_d;
          if (next_rowbase < cur_rows) begin
            rowbase_q <= next_rowbase;
            state_q   <= S_MAC;
          end else if (last_layer) begin
            out_q       <= nxt_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            rowbase_q <= '0;
            state_q   <= S_NEXT;
          end
        end
        S_NEXT: begin
          for (int i = 0; i < MAX_COL_ROWS; i++)
            act_q[i] <= (i < int'(cur_rows)) ? nxt_q[i] : '0;
          nxt_q   <= '0;
          layer_q <= layer_q + 1'b1;
          state_q <= S_MAC;
        end
        S_DONE: if (bus.out_taken) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.output_ready = out_valid_q;
  assign bus.mlp_output   = out_q;
  assign bus.cfg_err      = cfg_err_q;
endmodule

// File: tb/tb_mlp_seq_engine.sv
// Directed bench for mlp_seq_engine: one-lane and three-lane instances share stimulus.
module tb_mlp_seq_engine;
  typedef logic [8:0][7:0] vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mlp_seq_engine_if if1 ();
  mlp_seq_engine_if if3 ();

  mlp_seq_engine #(.NUM_LANES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  mlp_seq_engine #(.NUM_LANES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  assign if3.new_data       = if1.new_data;
  assign if3.input_data     = if1.input_data;
  assign if3.all_rows_sizes = if1.all_rows_sizes;
  assign if3.all_cols_sizes = if1.all_cols_sizes;
  assign if3.wt_we          = if1.wt_we;
  assign if3.wt_addr        = if1.wt_addr;
  assign if3.wt_data        = if1.wt_data;
  assign if3.out_taken      = if1.out_taken;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_layer(input int layer, input logic [7:0] val);
    for (int r = 0; r < 9; r++) begin
      for (int c = 0; c < 9; c++) begin
        if1.wt_we   = 1'b1;
        if1.wt_addr = 8'(layer * 81 + r * 9 + c);
        if1.wt_data = val;
        tick();
      end
    end
    if1.wt_we = 1'b0;
  endtask

  task automatic set_cfg(input vec_t din, input logic [5:0] r0, input logic [5:0] r1,
                         input logic [5:0] c0, input logic [5:0] c1);
    if1.input_data     = din;
    if1.all_rows_sizes = {r1, r0};
    if1.all_cols_sizes = {c1, c0};
  endtask

  // Accepts one transaction, records latency/result of both instances, then takes it.
  task automatic run_txn(input vec_t din, input logic [5:0] r0, input logic [5:0] r1,
                         input logic [5:0] c0, input logic [5:0] c1,
                         output int lat1, output int lat3, output vec_t o1, output vec_t o3);
    set_cfg(din, r0, r1, c0, c1);
    if1.new_data = 1'b1;
    tick();
    if1.new_data   = 1'b0;
    if1.input_data = '1;
    lat1 = -1; lat3 = -1; o1 = '0; o3 = '0;
    for (int c = 1; c <= 100 && (lat1 < 0 || lat3 < 0); c++) begin
      tick();
      if (lat1 < 0 && if1.output_ready) begin lat1 = c; o1 = if1.mlp_output; end
      if (lat3 < 0 && if3.output_ready) begin lat3 = c; o3 = if3.mlp_output; end
    end
    if1.out_taken = 1'b1;
    tick();
    if1.out_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_checks++; if (if1.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", if1.in_ready); end
    n_checks++; if (if1.output_ready !== 1'b0) begin n_fail++; $display("FAIL reset_output_ready got %b want 0", if1.output_ready); end
    n_checks++; if (if1.mlp_output !== '0) begin n_fail++; $display("FAIL reset_mlp_output got %h want 0", if1.mlp_output); end
    n_checks++; if (if1.cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err got %b want 0", if1.cfg_err); end
  endtask

  task automatic test_basic();
    vec_t din, exp, o1, o3;
    int lat1, lat3;
    din = '0; din[0] = 8'd1; din[1] = 8'd2;
    exp = '0; exp[0] = 8'd9;
    run_txn(din, 6'd3, 6'd1, 6'd2, 6'd3, lat1, lat3, o1, o3);
    n_checks++; if (o1 !== exp) begin n_fail++; $display("FAIL basic_out got %h want %h", o1, exp); end
    n_checks++; if (lat1 !== 14) begin n_fail++; $display("FAIL basic_latency got %0d want 14", lat1); end
    din = '0; din[0] = 8'd1;
    exp = '0; exp[0] = 8'd3;
    run_txn(din, 6'd3, 6'd1, 6'd2, 6'd3, lat1, lat3, o1, o3);
    n_checks++; if (o1 !== exp) begin n_fail++; $display("FAIL basic_in10_out got %h want %h", o1, exp); end
    n_checks++; if (o3 !== exp) begin n_fail++; $display("FAIL lanes3_in10_out got %h want %h", o3, exp); end
  endtask

  task automatic test_lanes();
    vec_t din, exp, o1, o3;
    int lat1, lat3;
    din = '0; din[0] = 8'd1; din[1] = 8'd2;
    exp = '0; exp[0] = 8'd9;
    run_txn(din, 6'd3, 6'd1, 6'd2, 6'd3, lat1, lat3, o1, o3);
    n_checks++; if (o3 !== exp) begin n_fail++; $display("FAIL lanes3_out got %h want %h", o3, exp); end
    n_checks++; if (lat3 !== 8) begin n_fail++; $display("FAIL lanes3_latency got %0d want 8", lat3); end
  endtask

  task automatic test_backpressure();
    vec_t din, exp, o1, o3;
    int lat, lat3, seen;
    din = '0; din[0] = 8'd1; din[1] = 8'd2;
    exp = '0; exp[0] = 8'd9;
    set_cfg(din, 6'd3, 6'd1, 6'd2, 6'd3);
    if1.new_data = 1'b1;
    tick();
    if1.new_data = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100 && lat < 0; c++) begin
      tick();
      if (if1.output_ready) lat = c;
    end
    n_checks++; if (lat !== 14) begin n_fail++; $display("FAIL bp_latency got %0d want 14", lat); end
    for (int h = 0; h < 5; h++) begin
      if1.new_data = 1'b1;
      if1.wt_we    = 1'b1;
      if1.wt_addr  = 8'd81;
      if1.wt_data  = 8'd50;
      tick();
      n_checks++; if (if1.output_ready !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cyc %0d got %b want 1", h, if1.output_ready); end
      n_checks++; if (if1.mlp_output !== exp) begin n_fail++; $display("FAIL bp_hold_out cyc %0d got %h want %h", h, if1.mlp_output, exp); end
      n_checks++; if (if1.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_in_ready cyc %0d got %b want 0", h, if1.in_ready); end
    end
    if1.new_data  = 1'b0;
    if1.wt_we     = 1'b0;
    if1.out_taken = 1'b1;
    tick();
    if1.out_taken = 1'b0;
    n_checks++; if (if1.output_ready !== 1'b0) begin n_fail++; $display("FAIL bp_taken_valid got %b want 0", if1.output_ready); end
    n_checks++; if (if1.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_taken_in_ready got %b want 1", if1.in_ready); end
    seen = 0;
    repeat (20) begin tick(); if (if1.output_ready) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL bp_new_data_ignored got %0d valid cycles want 0", seen); end
    run_txn(din, 6'd3, 6'd1, 6'd2, 6'd3, lat, lat3, o1, o3);
    n_checks++; if (o1 !== exp) begin n_fail++; $display("FAIL bp_write_dropped got %h want %h", o1, exp); end
    n_checks++; if (lat !== 14) begin n_fail++; $display("FAIL bp_after_latency got %0d want 14", lat); end
  endtask

  task automatic test_reset_mid();
    vec_t din, exp, o1, o3;
    int lat1, lat3, seen;
    din = '0; din[0] = 8'd1; din[1] = 8'd2;
    exp = '0; exp[0] = 8'd9;
    set_cfg(din, 6'd3, 6'd1, 6'd2, 6'd3);
    if1.new_data = 1'b1;
    tick();
    if1.new_data = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (20) begin tick(); if (if1.output_ready || if3.output_ready) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_output got %0d valid cycles want 0", seen); end
    n_checks++; if (if1.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got %b want 1", if1.in_ready); end
    n_checks++; if (if1.mlp_output !== '0) begin n_fail++; $display("FAIL rstmid_out_cleared got %h want 0", if1.mlp_output); end
    run_txn(din, 6'd3, 6'd1, 6'd2, 6'd3, lat1, lat3, o1, o3);
    n_checks++; if (o1 !== exp) begin n_fail++; $display("FAIL rstmid_after_out got %h want %h", o1, exp); end
    n_checks++; if (lat1 !== 14) begin n_fail++; $display("FAIL rstmid_after_latency got %0d want 14", lat1); end
  endtask

  task automatic test_relu();
    vec_t din, exp, o1, o3;
    int lat1, lat3;
    load_layer(0, 8'hFF);
    din = '0; din[0] = 8'd1; din[1] = 8'd2;
    exp = '0;
    run_txn(din, 6'd3, 6'd1, 6'd2, 6'd3, lat1, lat3, o1, o3);
    n_checks++; if (o1 !== exp) begin n_fail++; $display("FAIL relu_out got %h want %h", o1, exp); end
    n_checks++; if (o3 !== exp) begin n_fail++; $display("FAIL relu_lanes3_out got %h want %h", o3, exp); end
  endtask

  task automatic test_saturation();
    vec_t din, exp, o1, o3;
    int lat1, lat3;
    load_layer(0, 8'd127);
    load_layer(1, 8'd127);
    din = '0; din[0] = 8'd127; din[1] = 8'd127;
    exp = '0; exp[0] = 8'd127;
    run_txn(din, 6'd1, 6'd1, 6'd2, 6'd1, lat1, lat3, o1, o3);
    n_checks++; if (o1 !== exp) begin n_fail++; $display("FAIL sat_pos_out got %h want %h", o1, exp); end
    n_checks++; if (lat1 !== 6) begin n_fail++; $display("FAIL sat_latency got %0d want 6", lat1); end
    n_checks++; if (o3 !== exp) begin n_fail++; $display("FAIL sat_pos_lanes3_out got %h want %h", o3, exp); end
    load_layer(1, 8'h80);
    exp = '0; exp[0] = 8'h80;
    run_txn(din, 6'd1, 6'd1, 6'd2, 6'd1, lat1, lat3, o1, o3);
    n_checks++; if (o1 !== exp) begin n_fail++; $display("FAIL sat_neg_out got %h want %h", o1, exp); end
    n_checks++; if (o3 !== exp) begin n_fail++; $display("FAIL sat_neg_lanes3_out got %h want %h", o3, exp); end
  endtask

  task automatic test_cfg_err();
    vec_t din;
    int pulses, seen;
    din = '0; din[0] = 8'd1; din[1] = 8'd2;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) set_cfg(din, 6'd3, 6'd1, 6'd2, 6'd2);
      else        set_cfg(din, 6'd10, 6'd1, 6'd2, 6'd10);
      if1.new_data = 1'b1;
      tick();
      if1.new_data = 1'b0;
      pulses = int'(if1.cfg_err);
      seen = 0;
      repeat (20) begin
        tick();
        pulses += int'(if1.cfg_err);
        if (if1.output_ready) seen++;
      end
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL cfg_err_pulses case %0d got %0d want 1", t, pulses); end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL cfg_err_no_output case %0d got %0d want 0", t, seen); end
      n_checks++; if (if1.in_ready !== 1'b1) begin n_fail++; $display("FAIL cfg_err_in_ready case %0d got %b want 1", t, if1.in_ready); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst                = 1'b1;
    if1.new_data       = 1'b0;
    if1.input_data     = '0;
    if1.all_rows_sizes = '0;
    if1.all_cols_sizes = '0;
    if1.wt_we          = 1'b0;
    if1.wt_addr        = '0;
    if1.wt_data        = '0;
    if1.out_taken      = 1'b0;
    test_reset();
    load_layer(0, 8'd1);
    load_layer(1, 8'd1);
    test_basic();
    test_lanes();
    test_backpressure();
    test_reset_mid();
    test_relu();
    test_saturation();
    test_cfg_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/mlp_seq_engine.md
Name: mlp_seq_engine

Overview:
- Next-generation multi-layer perceptron core that evaluates the network with a time-multiplexed bank of NUM_LANES signed MAC lanes.
- Supersedes the fixed single-shot MLP. Adds:
  - valid/ready handshakes on input and output,
  - a run-time writable weight store,
  - ReLU and saturation,
  - configuration checking,
  - a lane count that sets throughput versus area.
- Sits between the feature front-end and the classifier output register.

Parameters:
- DATA_SIZE, 8, signed two's-complement width of activations and weights.
- NUM_LAYERS, 2, number of layers evaluated per transaction.
- MAX_COL_ROWS, 9, maximum rows or columns in any layer.
- MAX_COL_ROW_BITS, 6, width of each per-layer size field.
- LAYER_BITS, 2, width of the layer index.
- NUM_LANES, 1, neurons computed in parallel. Range 1..MAX_COL_ROWS.
- ACC_SIZE, 2*DATA_SIZE+4, signed accumulator width.
- FRAC_BITS, 0, arithmetic right shift applied to each accumulator before saturation.
- WT_ADDR_WIDTH, 8, weight address width. Must satisfy 2^WT_ADDR_WIDTH >= NUM_LAYERS*MAX_COL_ROWS^2.

Ports:
- clk, in, 1, single clock. All logic is synchronous to the rising edge.
- rst, in, 1, synchronous, active-high reset.
- new_data, in, 1, input valid.
- in_ready, out, 1, high only in IDLE.
- input_data, in, DATA_SIZE x MAX_COL_ROWS, input vector. Only entries below all_cols_sizes[0] are used.
- all_rows_sizes, in, MAX_COL_ROW_BITS x NUM_LAYERS, neurons per layer. Sampled at accept.
- all_cols_sizes, in, MAX_COL_ROW_BITS x NUM_LAYERS, inputs per layer. Sampled at accept.
- wt_we, in, 1, weight write enable.
- wt_addr, in, WT_ADDR_WIDTH, weight address = layer*MAX_COL_ROWS^2 + row*MAX_COL_ROWS + col.
- wt_data, in, DATA_SIZE, weight value.
- output_ready, out, 1, output valid. Held until taken.
- out_taken, in, 1, consumer ready.
- mlp_output, out, DATA_SIZE x MAX_COL_ROWS, final-layer vector. Entries at or above the last layer's row count are zero.
- cfg_err, out, 1, one-cycle pulse when a transaction is rejected.

Behaviour:
- Reset:
  - State goes to IDLE.
  - in_ready=1 on the cycle after rst deasserts; output_ready=0, mlp_output all 0, cfg_err=0.
  - Weight store is NOT cleared.
  - rst asserted mid-transaction aborts the transaction with no output.
- Accept: new_data&&in_ready on an edge.
  - Sizes and input_data are copied into the activation buffer on that edge.
  - Inputs may change afterwards without effect.
- Configuration check at accept. The transaction is rejected if any of the following holds:
  - any rows or cols is 0,
  - any rows or cols exceeds MAX_COL_ROWS,
  - cols[l+1] != rows[l] for any l.
- On rejection: cfg_err pulses on the next cycle, state stays IDLE, no output_ready.
- States: IDLE -> MAC -> WRITE -> (MAC | NEXT_LAYER | DONE); NEXT_LAYER -> MAC; DONE -> IDLE.
- MAC:
  - One column per cycle; lane k accumulates act[col]*W[layer][rowbase+k][col].
  - Product is sign-extended to ACC_SIZE.
  - Lanes with rowbase+k >= rows are idle and write nothing.
- WRITE:
  - Each result is arithmetic-shifted right by FRAC_BITS.
  - ReLU is applied on all layers except the last.
  - Result saturates to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
  - Result goes into the next-activation buffer, then accumulators clear and rowbase += NUM_LANES.
- NEXT_LAYER: next-activation buffer becomes the activation buffer; unused entries are zeroed.
- Latency: output_ready rises exactly 1 + sum_l ceil(rows_l/NUM_LANES)*(cols_l+1) cycles after accept.
- DONE:
  - output_ready=1 and mlp_output is stable while out_taken=0.
  - The edge with output_ready&&out_taken clears output_ready and returns to IDLE.
  - Back-to-back transactions have at least one idle cycle between them.
- Weight writes:
  - Honoured only while in_ready=1. Otherwise dropped silently.
  - A write and an accept on the same edge: the write lands first and the transaction uses the new weight.

Decomposition:
- Shared package mlp_pkg:
  - state enum,
  - ACC_SIZE helper,
  - saturate/relu function,
  - weight-address computation function.
- Sub-module mlp_mac_lane, one accumulator per lane:
  - ports: clk, rst, clr, en, a, w, acc;
  - instantiated NUM_LANES times via generate.

Test Plan:
- Defaults, all weights 1, input [1,2], rows {3,1}, cols {2,3} -> mlp_output[0]=9, other entries 0, output_ready exactly 14 cycles after accept.
- Same weights, input [1,0] -> mlp_output[0]=3. Layer-0 weights -1 with input [1,2] -> hidden ReLU 0 -> output 0.
- Saturation: input [127,127], all weights 127, rows {1,1}, cols {2,1}:
  - 32258 saturates to 127 at layer 0;
  - the final output 127*127 also saturates to 127.
  - Repeat with weights -128 on layer 1 -> final output -128.
- Config error: rows {3,1}, cols {2,2} -> cfg_err pulses once, no output_ready, in_ready stays 1. Rows0=10 -> same response.
- Backpressure and handshakes:
  - hold out_taken=0 for 5 cycles -> mlp_output stable, in_ready=0, and new_data plus a wt_we in that window are ignored.
  - NUM_LANES=3 with the first scenario -> same output, latency 1+3+4=8.
- Reset mid-MAC at cycle 5 -> no output_ready. A subsequent transaction gives the correct result using the previously written weights.
